// File: rtl/aes_encrypt_asmd.sv
// rtl/aes_encrypt_asmd.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
// Optional last_key output port guarded by AES_ENC_LAST_KEY_OUT_EN.
module aes_encrypt_asmd (
   input  logic         clock,
   input  logic         reset,
   input  logic         encrypt,
   input  logic [127:0] plain_text_in,
   input  logic [127:0] key_in,
   output logic [127:0] Dout,
   output logic         done,
`ifdef AES_ENC_LAST_KEY_OUT_EN
   output logic [127:0] last_key,
`endif
   output logic         busy
);

   typedef enum logic {IDLE, ROUND} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [3:0]   count_q, count_d;
   logic [127:0] dout_q, dout_d;
   logic         done_q, done_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
   logic [127:0] last_key_q, last_key_d;
`endif

   logic [127:0] sb, sr, mc, nk, round_out;
   logic [31:0]  t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // inverse as x^254 (= x^2 * x^4 * ... * x^128); maps 0 to 0 naturally
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] s, r;
      s = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] c);
      case (c)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // byte k of a block sits at [127-8k -: 8], k = row + 4*col
   always_comb begin
      for (int i = 0; i < 16; i++)
         sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      for (int c = 0; c < 4; c++)
         mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   always_comb begin
      t = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])}
          ^ {rcon(count_q), 24'h0};
      nk[127:96] = rkey_q[127:96] ^ t;
      nk[95:64]  = rkey_q[95:64]  ^ nk[127:96];
      nk[63:32]  = rkey_q[63:32]  ^ nk[95:64];
      nk[31:0]   = rkey_q[31:0]   ^ nk[63:32];
      round_out  = ((count_q == 4'd10) ? sr : mc) ^ nk;
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      count_d = count_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
      last_key_d = last_key_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (encrypt) begin
               state_d = plain_text_in ^ key_in;
               rkey_d  = key_in;
               count_d = 4'd1;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = round_out;
            rkey_d  = nk;
            count_d = count_q + 4'd1;
            if (count_q == 4'd10) begin
               dout_d = round_out;
               done_d = 1'b1;
               fsm_d  = IDLE;
`ifdef AES_ENC_LAST_KEY_OUT_EN
               last_key_d = nk;
`endif
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
         last_key_q <= '0;
`endif
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
         last_key_q <= last_key_d;
`endif
      end
   end

   assign Dout = dout_q;
   assign done = done_q;
   assign busy = (fsm_q == ROUND);
`ifdef AES_ENC_LAST_KEY_OUT_EN
   assign last_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_asmd.sv
// tb/tb_aes_encrypt_asmd.sv - directed FIPS-197 vector bench for aes_encrypt_asmd
module tb_aes_encrypt_asmd;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         encrypt = 1'b0;
   logic [127:0] plain_text_in = '0;
   logic [127:0] key_in = '0;
   logic [127:0] Dout;
   logic         done;
   logic         busy;
`ifdef AES_ENC_LAST_KEY_OUT_EN
   logic [127:0] last_key;
`endif

   int assertions = 0;
   int failures = 0;

   aes_encrypt_asmd dut (
      .clock(clock),
      .reset(reset),
      .encrypt(encrypt),
      .plain_text_in(plain_text_in),
      .key_in(key_in),
      .Dout(Dout),
      .done(done),
`ifdef AES_ENC_LAST_KEY_OUT_EN
      .last_key(last_key),
`endif
      .busy(busy)
   );

   always #5 clock = ~clock;

   // returns 1 ns after edge N, the edge that samples encrypt
   task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
      @(negedge clock);
      plain_text_in = pt;
      key_in = key;
      encrypt = 1'b1;
      @(posedge clock);
      #1;
      encrypt = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      assertions++;
      if (Dout !== 128'h0) begin failures++; $display("FAIL reset_dout got %h want 0", Dout); end
      assertions++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      #2 reset = 1'b0;
   endtask

   // done becomes visible just after edge N+10 and is sampled high at edge N+11
   task automatic test_fips_b;
      int cyc;
      bit overlap;
      bit busy_ok;
      overlap = 0;
      busy_ok = 1;
      start_block(PT_B, KEY_B);
      assertions++;
      if (busy !== 1'b1) begin failures++; $display("FAIL b_busy_start got %b want 1", busy); end
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(posedge clock);
         #1;
         cyc++;
         if (busy && done) overlap = 1;
         if (cyc < 10 && busy !== 1'b1) busy_ok = 0;
      end
      assertions++;
      if (cyc !== 10) begin failures++; $display("FAIL b_latency got %0d want 10", cyc); end
      assertions++;
      if (Dout !== CT_B) begin failures++; $display("FAIL b_dout got %h want %h", Dout, CT_B); end
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL b_busy_at_done got %b want 0", busy); end
      assertions++;
      if (busy_ok !== 1'b1) begin failures++; $display("FAIL b_busy_rounds got %b want 1", busy_ok); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
      assertions++;
      if (last_key !== LK_B) begin failures++; $display("FAIL b_last_key got %h want %h", last_key, LK_B); end
`endif
      @(posedge clock);
      #1;
      assertions++;
      if (done !== 1'b0) begin failures++; $display("FAIL b_done_clear got %b want 0", done); end
      assertions++;
      if (overlap !== 1'b0) begin failures++; $display("FAIL b_busy_done_overlap got %b want 0", overlap); end
   endtask

   task automatic test_fips_c1;
      int cyc;
      start_block(PT_C, KEY_C);
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      assertions++;
      if (cyc !== 10) begin failures++; $display("FAIL c1_latency got %0d want 10", cyc); end
      assertions++;
      if (Dout !== CT_C) begin failures++; $display("FAIL c1_dout got %h want %h", Dout, CT_C); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      int first;
      @(negedge clock);
      plain_text_in = '0;
      key_in = '0;
      encrypt = 1'b1;
      @(posedge clock);
      #1;
      plain_text_in = PT_B;
      key_in = KEY_B;
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      first = cyc;
      assertions++;
      if (Dout !== CT_Z) begin failures++; $display("FAIL zero_dout got %h want %h", Dout, CT_Z); end
      @(posedge clock);
      #1;
      cyc++;
      while (done !== 1'b1 && cyc < 60) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      encrypt = 1'b0;
      assertions++;
      if (cyc - first !== 11) begin failures++; $display("FAIL b2b_spacing got %0d want 11", cyc - first); end
      assertions++;
      if (Dout !== CT_B) begin failures++; $display("FAIL b2b_dout got %h want %h", Dout, CT_B); end
      repeat (3) @(posedge clock);
      #1;
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got %b want 0", busy); end
   endtask

   task automatic test_ignore_busy;
      int dones;
      logic [127:0] seen;
      dones = 0;
      seen = '0;
      start_block(PT_C, KEY_C);
      repeat (4) @(posedge clock);
      #1;
      plain_text_in = PT_B;
      key_in = KEY_B;
      encrypt = 1'b1;
      @(posedge clock);
      #1;
      encrypt = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done === 1'b1) begin
            dones++;
            seen = Dout;
         end
         @(posedge clock);
         #1;
      end
      assertions++;
      if (dones !== 1) begin failures++; $display("FAIL ignore_done_count got %0d want 1", dones); end
      assertions++;
      if (seen !== CT_C) begin failures++; $display("FAIL ignore_dout got %h want %h", seen, CT_C); end
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      start_block(PT_B, KEY_B);
      repeat (6) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      assertions++;
      if (Dout !== 128'h0) begin failures++; $display("FAIL rst_mid_dout got %h want 0", Dout); end
      assertions++;
      if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got %b want 0", done); end
      assertions++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      #3 reset = 1'b0;
      start_block(PT_C, KEY_C);
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      assertions++;
      if (cyc !== 10) begin failures++; $display("FAIL rst_after_latency got %0d want 10", cyc); end
      assertions++;
      if (Dout !== CT_C) begin failures++; $display("FAIL rst_after_dout got %h want %h", Dout, CT_C); end
   endtask

   initial begin
      test_reset;
      test_fips_b;
      test_fips_c1;
      test_back_to_back;
      test_ignore_busy;
      test_reset_mid;
      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
